// File: rtl/multi_pulse_stretcher.sv
// Multi-channel pulse stretcher: each channel turns a trigger into a gate of
// len_i clocks followed by holdoff_i dead clocks; rejected triggers are counted.

module msp_chan #(
  parameter int CNT_W = 8,
  parameter int EDGE  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             pulse_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [CNT_W-1:0] holdoff_i,
  input  logic             retrig_i,
  output logic             gate_o,
  output logic             start_o,
  output logic             busy_o,
  output logic             rej_o
);
  typedef enum logic [1:0] {IDLE, GATE, HOLD} st_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  st_t              st;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             trig;
  logic [CNT_W-1:0] len_m1;

  // arm_i masks the first cycle after reset so a level held through release is not an edge
  assign trig   = (EDGE != 0) ? (pulse_i & ~prev & arm_i) : pulse_i;
  assign len_m1 = (len_i == '0) ? '0 : len_i - ONE;
  assign busy_o = (st != IDLE);

  // The last HOLD cycle behaves as IDLE for triggers, giving spacing L + holdoff
  assign rej_o  = ~rst_i & trig &
                  (((st == GATE) & ~retrig_i) | ((st == HOLD) & (cnt != '0)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st      <= IDLE;
      cnt     <= '0;
      prev    <= 1'b0;
      gate_o  <= 1'b0;
      start_o <= 1'b0;
    end else begin
      prev    <= pulse_i;
      start_o <= 1'b0;
      case (st)
        IDLE: if (trig) begin
          st      <= GATE;
          cnt     <= len_m1;
          gate_o  <= 1'b1;
          start_o <= 1'b1;
        end
        GATE: begin
          if (trig && retrig_i) begin
            cnt <= len_m1;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (holdoff_i != '0) begin
            st     <= HOLD;
            cnt    <= holdoff_i - ONE;
            gate_o <= 1'b0;
          end else begin
            st     <= IDLE;
            gate_o <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (trig) begin
            st      <= GATE;
            cnt     <= len_m1;
            gate_o  <= 1'b1;
            start_o <= 1'b1;
          end else begin
            st <= IDLE;
          end
        end
        default: begin
          st     <= IDLE;
          gate_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

module multi_pulse_stretcher #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int EDGE  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   pulse_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [CNT_W-1:0] holdoff_i,
  input  logic             retrig_i,
  input  logic             drop_clr_i,
  output logic [NCH-1:0]   gate_o,
  output logic [NCH-1:0]   start_o,
  output logic             busy_o,
  output logic [15:0]      drop_cnt_o
);
  localparam int SW = $clog2(NCH + 1);

  logic [NCH-1:0] busy_ch;
  logic [NCH-1:0] rej;
  logic [SW-1:0]  rej_sum;
  logic [16:0]    drop_add;
  logic           arm_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) arm_q <= 1'b0;
    else       arm_q <= 1'b1;
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    msp_chan #(.CNT_W(CNT_W), .EDGE(EDGE)) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .arm_i     (arm_q),
      .pulse_i   (pulse_i[n]),
      .len_i     (len_i),
      .holdoff_i (holdoff_i),
      .retrig_i  (retrig_i),
      .gate_o    (gate_o[n]),
      .start_o   (start_o[n]),
      .busy_o    (busy_ch[n]),
      .rej_o     (rej[n])
    );
  end

  assign busy_o = |busy_ch;

  always_comb begin
    rej_sum = '0;
    for (int i = 0; i < NCH; i++) rej_sum = rej_sum + SW'(rej[i]);
  end

  // 17-bit sum so a carry out of bit 15 means saturate
  assign drop_add = {1'b0, drop_cnt_o} + 17'(rej_sum);

  always_ff @(posedge clk_i) begin
    if (rst_i || drop_clr_i) drop_cnt_o <= '0;
    else if (drop_add[16])   drop_cnt_o <= 16'hFFFF;
    else                     drop_cnt_o <= drop_add[15:0];
  end
endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Bench for multi_pulse_stretcher: an EDGE=1 and an EDGE=0 instance checked
// every cycle against a gate/hold countdown model plus directed literal checks.

module tb_multi_pulse_stretcher;
  localparam int NCH = 4;

  logic           clk = 0;
  logic           rst_i = 1;
  logic [NCH-1:0] pulse = '0, pulse0 = '0;
  logic [7:0]     len_i = 8'd1, holdoff_i = 8'd0;
  logic           retrig_i = 0, drop_clr_i = 0;

  logic [NCH-1:0] gate_e1, start_e1, gate_e0, start_e0;
  logic           busy_e1, busy_e0;
  logic [15:0]    drop_e1, drop_e0;

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 0;

  multi_pulse_stretcher #(.NCH(NCH), .CNT_W(8), .EDGE(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .pulse_i(pulse), .len_i(len_i), .holdoff_i(holdoff_i),
    .retrig_i(retrig_i), .drop_clr_i(drop_clr_i), .gate_o(gate_e1), .start_o(start_e1),
    .busy_o(busy_e1), .drop_cnt_o(drop_e1));

  multi_pulse_stretcher #(.NCH(NCH), .CNT_W(8), .EDGE(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .pulse_i(pulse0), .len_i(len_i), .holdoff_i(holdoff_i),
    .retrig_i(retrig_i), .drop_clr_i(drop_clr_i), .gate_o(gate_e0), .start_o(start_e0),
    .busy_o(busy_e0), .drop_cnt_o(drop_e0));

  always #5 clk = ~clk;

  // Model: g = gate clocks left (incl. current), h = hold clocks left (incl. current)
  int             g [2][NCH];
  int             h [2][NCH];
  bit             prv [2][NCH];
  bit             first [2];
  int             drop [2];
  logic [NCH-1:0] es [2];

  task automatic model_step();
    logic [NCH-1:0] pv;
    int rej, L;
    bit trig;
    for (int d = 0; d < 2; d++) begin
      pv = (d == 0) ? pulse : pulse0;
      es[d] = '0;
      if (rst_i) begin
        for (int n = 0; n < NCH; n++) begin g[d][n] = 0; h[d][n] = 0; prv[d][n] = 0; end
        first[d] = 1;
        drop[d] = 0;
      end else begin
        rej = 0;
        L = (len_i == 0) ? 1 : int'(len_i);
        for (int n = 0; n < NCH; n++) begin
          trig = (d == 0) ? (pv[n] && !prv[d][n] && !first[d]) : pv[n];
          prv[d][n] = pv[n];
          if (g[d][n] > 0) begin
            if (trig && retrig_i) g[d][n] = L;
            else begin
              if (trig) rej++;
              g[d][n]--;
              if (g[d][n] == 0) h[d][n] = int'(holdoff_i);
            end
          end else if (h[d][n] > 0) begin
            if (trig && h[d][n] == 1) begin h[d][n] = 0; g[d][n] = L; es[d][n] = 1; end
            else begin if (trig) rej++; h[d][n]--; end
          end else if (trig) begin
            g[d][n] = L; es[d][n] = 1;
          end
        end
        first[d] = 0;
        if (drop_clr_i) drop[d] = 0;
        else drop[d] = (drop[d] + rej > 65535) ? 65535 : drop[d] + rej;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    cmp_en = 1;
  end

  initial forever begin
    logic [NCH-1:0] eg;
    bit eb;
    @(negedge clk);
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        eb = 0;
        for (int n = 0; n < NCH; n++) begin
          eg[n] = g[d][n] > 0;
          if (g[d][n] > 0 || h[d][n] > 0) eb = 1;
        end
        chk(d == 0 ? "m_gate_e1"  : "m_gate_e0",  d == 0 ? 32'(gate_e1)  : 32'(gate_e0),  32'(eg));
        chk(d == 0 ? "m_start_e1" : "m_start_e0", d == 0 ? 32'(start_e1) : 32'(start_e0), 32'(es[d]));
        chk(d == 0 ? "m_busy_e1"  : "m_busy_e0",  d == 0 ? 32'(busy_e1)  : 32'(busy_e0),  32'(eb));
        chk(d == 0 ? "m_drop_e1"  : "m_drop_e0",  d == 0 ? 32'(drop_e1)  : 32'(drop_e0),  32'(drop[d]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int cnt;
    step(3);
    chk("rst_gate", 32'(gate_e1), 0);
    chk("rst_busy", 32'(busy_e1), 0);
    chk("rst_drop", 32'(drop_e1), 0);
    rst_i = 0;
    step(2);

    // basic gate, len 5
    len_i = 5; holdoff_i = 0; retrig_i = 0;
    pulse = 4'b0001; step(1); pulse = 0;
    for (int k = 0; k <= 5; k++) begin
      chk("basic_gate", 32'(gate_e1[0]), (k <= 4) ? 1 : 0);
      chk("basic_start", 32'(start_e1[0]), (k == 0) ? 1 : 0);
      step(1);
    end
    chk("basic_drop", 32'(drop_e1), 0);
    step(4);

    // retrigger extension, len 4, second pulse 3 clocks later
    len_i = 4; retrig_i = 1;
    pulse = 4'b0001; step(1); pulse = 0;
    chk("retrig_start0", 32'(start_e1[0]), 1);
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) pulse = 4'b0001;
      step(1); pulse = 0;
      chk("retrig_gate", 32'(gate_e1[0]), (k <= 6) ? 1 : 0);
      chk("retrig_start", 32'(start_e1[0]), 0);
    end
    step(4);

    // len 0 behaves as 1
    len_i = 0; retrig_i = 0;
    pulse = 4'b0010; step(1); pulse = 0;
    chk("len0_gate_on", 32'(gate_e1), 32'h2);
    step(1);
    chk("len0_gate_off", 32'(gate_e1), 0);
    step(4);

    // reject and count across all channels with holdoff
    drop_clr_i = 1; step(1); drop_clr_i = 0;
    len_i = 4; holdoff_i = 3; retrig_i = 0;
    pulse = 4'hF; step(1); pulse = 0;      // edge t
    chk("rej_gate", 32'(gate_e1), 32'hF);
    step(1);                                // t+1
    pulse = 4'hF; step(1); pulse = 0;      // t+2: all rejected
    chk("rej_drop4", 32'(drop_e1), 4);
    step(2);                                // t+4: into hold
    chk("rej_hold_gate", 32'(gate_e1), 0);
    chk("rej_hold_busy", 32'(busy_e1), 1);
    step(1);                                // t+5
    pulse = 4'b0001; step(1); pulse = 0;   // t+6: rejected in hold
    chk("rej_drop5", 32'(drop_e1), 5);
    chk("rej_t6_gate", 32'(gate_e1), 0);
    pulse = 4'b0010; step(1); pulse = 0;   // t+7: accepted
    chk("acc_t7_start", 32'(start_e1), 32'h2);
    chk("acc_t7_gate", 32'(gate_e1), 32'h2);
    chk("acc_t7_drop", 32'(drop_e1), 5);
    step(12);

    // level mode: held 10 clocks, len 2, retrig -> 11 clock gate
    len_i = 2; holdoff_i = 0; retrig_i = 1;
    pulse0 = 4'b0001; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (i == 9) pulse0 = 0;
      if (gate_e0[0]) cnt++;
    end
    chk("lvl_len", 32'(cnt), 11);
    step(3);

    // reset mid-gate
    len_i = 6; holdoff_i = 4; retrig_i = 0;
    pulse = 4'b0001; step(1); pulse = 0; step(2);
    rst_i = 1; step(1);
    chk("rstg_gate", 32'(gate_e1), 0);
    chk("rstg_busy", 32'(busy_e1), 0);
    rst_i = 0; step(1);
    chk("rstg_start", 32'(start_e1), 0);
    step(2);

    // reset mid-hold, then level held through release
    len_i = 2; holdoff_i = 5;
    pulse = 4'b0001; step(1); pulse = 0; step(3);
    chk("rsth_pre_busy", 32'(busy_e1), 1);
    chk("rsth_pre_gate", 32'(gate_e1), 0);
    rst_i = 1; step(1);
    chk("rsth_busy", 32'(busy_e1), 0);
    pulse = 4'hF; step(2); rst_i = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("held_gate", 32'(gate_e1), 0);
      chk("held_start", 32'(start_e1), 0);
    end
    chk("held_drop", 32'(drop_e1), 0);
    pulse = 0; step(2);

    // drive the level-mode counter into saturation
    len_i = 255; holdoff_i = 255; retrig_i = 0; pulse0 = 4'hF;
    for (int i = 0; i < 20000 && drop_e0 != 16'hFFFF; i++) step(1);
    chk("sat_reach", 32'(drop_e0), 32'hFFFF);
    step(300);
    chk("sat_hold", 32'(drop_e0), 32'hFFFF);
    drop_clr_i = 1; step(1); drop_clr_i = 0;
    chk("sat_clr", 32'(drop_e0), 0);
    pulse0 = 0; step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_pulse_stretcher.md
MULTI_PULSE_STRETCHER -- requirements
Module: multi_pulse_stretcher

Interface
REQ-001 Parameter NCH, default 4: number of independent channels; legal range 1..32.
REQ-002 Parameter CNT_W, default 8: width of the gate-length and holdoff counters.
REQ-003 Parameter EDGE, default 1: 1 = a trigger is a rising edge of pulse_i[n]; 0 = a trigger is any cycle with pulse_i[n] high.
REQ-004 clk_i  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 pulse_i  in  NCH  per-channel trigger inputs, already synchronous to clk_i.
REQ-007 len_i  in  CNT_W  gate length in clocks; value 0 is treated as 1.
REQ-008 holdoff_i  in  CNT_W  dead time in clocks after a gate ends; 0 = no dead time.
REQ-009 retrig_i  in  1  1 = a trigger during a gate restarts the gate length; 0 = it is ignored.
REQ-010 drop_clr_i  in  1  synchronous clear of drop_cnt_o.
REQ-011 gate_o  out  NCH  registered per-channel stretched gate.
REQ-012 start_o  out  NCH  one-cycle strobe, high in the first cycle of each new gate (not on retrigger extension).
REQ-013 busy_o  out  1  OR of all channels not in IDLE.
REQ-014 drop_cnt_o  out  16  saturating count of rejected triggers, summed over all channels.

Function
REQ-015 Each channel shall run an independent FSM with states IDLE, GATE and HOLD, plus a CNT_W-bit down-counter.
REQ-016 With EDGE=1, each channel shall register pulse_i[n] (reset value 0) and shall treat pulse_i[n] & ~previous as the trigger.
REQ-017 IDLE + trigger at edge t -> GATE and load the counter with max(len_i,1)-1; gate_o[n] is high for cycles t+1 .. t+L, where L = max(len_i,1).
REQ-018 In GATE with counter != 0, the counter shall decrement by 1 each clock.
REQ-019 In GATE with counter == 0 and no accepted retrigger, the FSM shall go to HOLD and load holdoff_i-1 if holdoff_i != 0; otherwise it shall go to IDLE.
REQ-020 In GATE with retrig_i=1, a trigger shall reload max(len_i,1)-1 and keep GATE; this includes a trigger in the final cycle, where the reload wins over exit.
REQ-021 In GATE with retrig_i=0, a trigger shall be rejected.
REQ-022 In HOLD, gate_o[n]=0 and the counter shall decrement; at counter == 0 the FSM goes to IDLE on the next edge.
REQ-023 In HOLD, every trigger shall be rejected, regardless of retrig_i.
REQ-024 len_i and holdoff_i shall be sampled only when loaded; changing them mid-gate shall not alter the active count.
REQ-025 Minimum spacing between accepted triggers with retrig_i=0 is L + holdoff_i cycles; an IDLE trigger in the cycle right after HOLD exits shall be accepted.
REQ-026 gate_o[n] shall be 1 exactly when the channel is in GATE.
REQ-027 start_o[n] shall be 1 only in the cycle the channel enters GATE from IDLE.
REQ-028 drop_cnt_o shall add the number of channels rejecting a trigger in a given cycle (0..NCH) in one update, and shall saturate at 16'hFFFF with no wrap.
REQ-029 When drop_clr_i=1, drop_cnt_o shall be 0 on the next edge, and rejects in that same cycle shall not be counted.
REQ-030 Channels shall not interact, except through busy_o and drop_cnt_o.

Reset
REQ-031 With rst_i=1 at a clock edge, all FSMs go to IDLE, and counters, edge registers, gate_o, start_o, busy_o and drop_cnt_o go to 0.
REQ-032 Reset asserted mid-gate or mid-hold shall drop gate_o on the next edge, and no start_o shall follow.
REQ-033 Triggers present while rst_i=1 shall be ignored and not counted.
REQ-034 With EDGE=1, a pulse_i level held high through reset release shall not trigger.

Verification
REQ-035 Basic gate: EDGE=1, len_i=5, holdoff_i=0, one-cycle pulse on ch0 at edge t -> gate_o[0] high t+1..t+5, start_o[0] at t+1, drop_cnt_o=0.
REQ-036 Retrigger: len_i=4, retrig_i=1, pulses at t and t+3 -> gate_o high t+1..t+7 continuously, single start_o.
REQ-037 Reject and count: len_i=4, holdoff_i=3, retrig_i=0, pulses on all 4 channels at t and t+2 -> gates t+1..t+4, drop_cnt_o=4 at t+3; pulse at t+6 rejected, pulse at t+7 accepted.
REQ-038 Edge cases: len_i=0 gives a 1-cycle gate; EDGE=0 with pulse held high 10 cycles and len_i=2, retrig_i=1 gives a gate of 11 cycles; drop_cnt_o forced toward saturation holds at FFFF.
REQ-039 Reset mid-operation: rst_i pulsed during GATE and then HOLD -> all outputs 0 the next cycle; a held-high pulse_i with EDGE=1 gives no gate after release.
